// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: packs the valid slots of each fetch group into a
// circular buffer and presents the oldest entries to decode.
package instr_fetch_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  valid;
  } fetched_instr_t;
endpackage

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

module instr_fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int FETCH_WIDTH  = `FETCH_WIDTH,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  fetched_instr_t [0:FETCH_WIDTH-1]    i_instrs,
  output logic                                o_stall,
  input  logic                                i_flush,
  input  logic                                i_deq_ready,
  output fetched_instr_t [0:DECODE_WIDTH-1]   o_instrs,
  output logic [$clog2(DEPTH):0]              o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  fetched_instr_t   mem_r [DEPTH];

  logic [PTR_W-1:0]       offs_s [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] slot_vld_s;
  logic [CNT_W-1:0]       n_enq_s;
  logic [CNT_W-1:0]       n_deq_s;
  logic [CNT_W-1:0]       free_s;
  logic                   stall_s;
  logic                   accept_s;
  logic [PTR_W-1:0]       head_nxt_s;
  logic [PTR_W-1:0]       tail_nxt_s;
  logic [CNT_W-1:0]       count_nxt_s;

  // Compaction: each valid slot's offset is the number of valid slots below it.
  always_comb begin
    n_enq_s    = '0;
    slot_vld_s = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      offs_s[s]     = n_enq_s[PTR_W-1:0];
      slot_vld_s[s] = |i_instrs[s].valid;
      if (slot_vld_s[s]) begin
        n_enq_s = n_enq_s + CNT_W'(1);
      end else begin
        n_enq_s = n_enq_s;
      end
    end
  end

  // Backpressure and dequeue amount, both derived from registered state.
  always_comb begin
    free_s   = CNT_W'(DEPTH) - count_r;
    stall_s  = (free_s < CNT_W'(FETCH_WIDTH));
    accept_s = !stall_s && !i_flush;
    if (!i_deq_ready) begin
      n_deq_s = '0;
    end else if (count_r < CNT_W'(DECODE_WIDTH)) begin
      n_deq_s = count_r;
    end else begin
      n_deq_s = CNT_W'(DECODE_WIDTH);
    end
  end

  // Pointer and occupancy next-state; flush overrides enqueue and dequeue.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (i_flush) begin
      head_nxt_s  = '0;
      tail_nxt_s  = '0;
      count_nxt_s = '0;
    end else begin
      head_nxt_s = head_r + n_deq_s[PTR_W-1:0];
      if (accept_s) begin
        tail_nxt_s  = tail_r + n_enq_s[PTR_W-1:0];
        count_nxt_s = count_r + n_enq_s - n_deq_s;
      end else begin
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r - n_deq_s;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are qualified by count so they need no reset.
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      if (accept_s && slot_vld_s[s]) begin
        mem_r[tail_r + offs_s[s]] <= i_instrs[s];
      end
    end
  end

  // Decode view: oldest entries first, empty slots forced to zero.
  always_comb begin
    o_instrs = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (CNT_W'(k) < count_r) begin
        o_instrs[k] = mem_r[head_r + PTR_W'(k)];
      end else begin
        o_instrs[k] = '0;
      end
    end
  end

  assign o_stall = stall_s;
  assign o_count = count_r;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue with default parameters.
module tb_instr_fetch_queue;
  import instr_fetch_pkg::*;

  localparam int FW    = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 16;

  logic                        i_clk;
  logic                        i_rst;
  fetched_instr_t [0:FW-1]     i_instrs;
  logic                        o_stall;
  logic                        i_flush;
  logic                        i_deq_ready;
  fetched_instr_t [0:DW-1]     o_instrs;
  logic [$clog2(DEPTH):0]      o_count;

  int n_cmp = 0;
  int n_err = 0;
  int seq   = 0;
  fetched_instr_t sb_q[$];

  instr_fetch_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_instrs    (i_instrs),
    .o_stall     (o_stall),
    .i_flush     (i_flush),
    .i_deq_ready (i_deq_ready),
    .o_instrs    (o_instrs),
    .o_count     (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Build a group; slots in mask get fresh instructions with nonzero valid.
  task automatic mk_grp(input logic [FW-1:0] mask, output fetched_instr_t [0:FW-1] g);
    for (int s = 0; s < FW; s++) begin
      if (mask[s]) begin
        g[s].instr = 32'hC000_0000 + 32'(seq);
        g[s].valid = 2'($urandom_range(3, 1));
        seq++;
      end else begin
        g[s].instr = 32'hDEAD_0000 + 32'(s);
        g[s].valid = 2'b00;
      end
    end
  endtask

  // One cycle: compare DUT view with the scoreboard, drive, update model.
  task automatic cycle(input fetched_instr_t [0:FW-1] grp, input logic fl,
                       input logic rdy, output logic acc);
    int             n_deq;
    logic           stall_m;
    fetched_instr_t e;
    stall_m = ((DEPTH - sb_q.size()) < FW);
    chk("count", 64'(o_count), 64'(sb_q.size()));
    chk("stall", 64'(o_stall), 64'(stall_m));
    for (int k = 0; k < DW; k++) begin
      e = (k < sb_q.size()) ? sb_q[k] : '0;
      chk($sformatf("slot%0d", k), 64'(o_instrs[k]), 64'(e));
    end
    i_instrs    = grp;
    i_flush     = fl;
    i_deq_ready = rdy;
    acc = !stall_m && !fl;
    if (fl) begin
      sb_q.delete();
    end else begin
      n_deq = rdy ? ((sb_q.size() < DW) ? sb_q.size() : DW) : 0;
      for (int k = 0; k < n_deq; k++) void'(sb_q.pop_front());
      if (acc) begin
        for (int s = 0; s < FW; s++) if (grp[s].valid != 2'b00) sb_q.push_back(grp[s]);
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    fetched_instr_t [0:FW-1] g;
    fetched_instr_t [0:FW-1] z;
    fetched_instr_t          e;
    logic                    acc;
    int                      first;

    z = '0;
    i_rst = 1'b1; i_instrs = '0; i_flush = 1'b0; i_deq_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_slot0", 64'(o_instrs[0]), 64'd0);

    // Compaction: valid {01,00,11,00}, instrs {A,B,C,D}
    g[0].instr = 32'hA; g[0].valid = 2'b01;
    g[1].instr = 32'hB; g[1].valid = 2'b00;
    g[2].instr = 32'hC; g[2].valid = 2'b11;
    g[3].instr = 32'hD; g[3].valid = 2'b00;
    cycle(g, 1'b0, 1'b0, acc);
    e.instr = 32'hA; e.valid = 2'b01;
    chk("cmp_slot0", 64'(o_instrs[0]), 64'(e));
    e.instr = 32'hC; e.valid = 2'b11;
    chk("cmp_slot1", 64'(o_instrs[1]), 64'(e));
    chk("cmp_count", 64'(o_count), 64'd2);
    cycle(z, 1'b0, 1'b1, acc);
    chk("cmp_drained", 64'(o_count), 64'd0);
    cycle(z, 1'b0, 1'b1, acc);   // empty queue, ready has no effect

    // Fill to stall, then hold a group during stall
    for (int i = 0; i < 4; i++) begin
      mk_grp(4'b1111, g);
      cycle(g, 1'b0, 1'b0, acc);
    end
    chk("full_stall", 64'(o_stall), 64'd1);
    chk("full_count", 64'(o_count), 64'd16);
    mk_grp(4'b1111, g);
    repeat (3) cycle(g, 1'b0, 1'b0, acc);
    chk("held_count", 64'(o_count), 64'd16);
    repeat (9) cycle(z, 1'b0, 1'b1, acc);

    // Steady state: full groups, fetch holds while stalled, several wraps
    mk_grp(4'b1111, g);
    for (int i = 0; i < 80; i++) begin
      cycle(g, 1'b0, 1'b1, acc);
      if (acc) mk_grp(4'b1111, g);
    end
    repeat (10) cycle(z, 1'b0, 1'b1, acc);

    // Sparse groups and an all-empty no-op group
    for (int i = 0; i < 12; i++) begin
      mk_grp(4'($urandom_range(15, 0)), g);
      cycle(g, 1'b0, 1'($urandom_range(1, 0)), acc);
    end
    repeat (10) cycle(z, 1'b0, 1'b1, acc);

    // Flush priority at count 10
    mk_grp(4'b1111, g); cycle(g, 1'b0, 1'b0, acc);
    mk_grp(4'b1111, g); cycle(g, 1'b0, 1'b0, acc);
    mk_grp(4'b0101, g); cycle(g, 1'b0, 1'b0, acc);
    chk("pre_flush_count", 64'(o_count), 64'd10);
    mk_grp(4'b1111, g);
    cycle(g, 1'b1, 1'b1, acc);
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_stall", 64'(o_stall), 64'd0);
    chk("flush_slot0", 64'(o_instrs[0]), 64'd0);
    mk_grp(4'b0110, g);
    first = seq - 2;
    cycle(g, 1'b0, 1'b0, acc);
    chk("post_flush_slot0", 64'(o_instrs[0].instr), 64'(32'hC000_0000 + 32'(first)));
    repeat (3) cycle(z, 1'b0, 1'b1, acc);

    // Asynchronous reset between edges at count 7
    mk_grp(4'b1111, g); cycle(g, 1'b0, 1'b0, acc);
    mk_grp(4'b1011, g); cycle(g, 1'b0, 1'b0, acc);
    chk("pre_rst_count", 64'(o_count), 64'd7);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_count", 64'(o_count), 64'd0);
    chk("arst_slot0", 64'(o_instrs[0]), 64'd0);
    chk("arst_slot1", 64'(o_instrs[1]), 64'd0);
    sb_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    mk_grp(4'b1111, g);
    cycle(g, 1'b0, 1'b0, acc);
    chk("post_rst_count", 64'(o_count), 64'd4);

    // Partial dequeue with count 1
    repeat (2) cycle(z, 1'b0, 1'b1, acc);
    mk_grp(4'b0100, g);
    cycle(g, 1'b0, 1'b0, acc);
    chk("part_slot0_vld", 64'(o_instrs[0].valid != 2'b00), 64'd1);
    chk("part_slot1", 64'(o_instrs[1]), 64'd0);
    cycle(z, 1'b0, 1'b1, acc);
    chk("part_count", 64'(o_count), 64'd0);
    cycle(z, 1'b0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
